// File: rtl/nanorv32_gpio_pkg.sv
// rtl/nanorv32_gpio_pkg.sv - register offsets, bus FSM encoding and lane helper for the GPIO block
package nanorv32_gpio_pkg;

  localparam logic [2:0] GPIO_DATA_OUT = 3'd0;
  localparam logic [2:0] GPIO_DATA_IN  = 3'd1;
  localparam logic [2:0] GPIO_DIR      = 3'd2;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd3;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd4;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd5;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd6;
  localparam logic [2:0] GPIO_RSVD     = 3'd7;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_DONE = 1'b1
  } gpio_state_e;

  // Expand the four byte-lane selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] bytesel);
    return {{8{bytesel[3]}}, {8{bytesel[2]}}, {8{bytesel[1]}}, {8{bytesel[0]}}};
  endfunction

endpackage

// File: rtl/nanorv32_gpio_sync.sv
// rtl/nanorv32_gpio_sync.sv - per-pin two-flop synchroniser with rising-edge detect
module nanorv32_gpio_sync #(
  parameter int NB_GPIO = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NB_GPIO-1:0] async_i,
  output logic [NB_GPIO-1:0] sync_o,
  output logic [NB_GPIO-1:0] rise_o
);

  logic [NB_GPIO-1:0] meta_q;
  logic [NB_GPIO-1:0] sync_q;
  logic [NB_GPIO-1:0] prev_q;

  // Two metastability stages, then one cycle of history so a rise is seen exactly once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/nanorv32_gpio.sv
// rtl/nanorv32_gpio.sv - register-mapped GPIO with bus FSM, set/clear aliases and edge interrupts
module nanorv32_gpio
  import nanorv32_gpio_pkg::*;
#(
  parameter int NB_GPIO = 32,
  parameter int ADDR_W  = 32
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  bus_gpio_addr,
  input  logic [3:0]         bus_gpio_bytesel,
  input  logic [31:0]        bus_gpio_din,
  input  logic               bus_gpio_en,
  output logic [31:0]        gpio_bus_dout,
  output logic               gpio_bus_ready_nxt,
  input  logic [NB_GPIO-1:0] gpio_in,
  output logic [NB_GPIO-1:0] gpio_out,
  output logic [NB_GPIO-1:0] gpio_oe,
  output logic               gpio_irq
);

  gpio_state_e        state_q, state_d;
  logic [NB_GPIO-1:0] data_out_q, data_out_d;
  logic [NB_GPIO-1:0] dir_q, dir_d;
  logic [NB_GPIO-1:0] irq_en_q, irq_en_d;
  logic [NB_GPIO-1:0] irq_stat_q, irq_stat_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic [NB_GPIO-1:0] in_sync, in_rise;
  logic [2:0]         reg_sel;
  logic [31:0]        mask32;
  logic [NB_GPIO-1:0] wmask, wbits;
  logic               wr_en, rd_cap;
  logic               unused_bits;

  nanorv32_gpio_sync #(.NB_GPIO(NB_GPIO)) u_sync (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .async_i(gpio_in),
    .sync_o (in_sync),
    .rise_o (in_rise)
  );

  // Only addr[4:2] decode; everything above aliases onto the eight registers.
  assign reg_sel     = bus_gpio_addr[4:2];
  assign mask32      = lane_mask(bus_gpio_bytesel);
  assign wmask       = mask32[NB_GPIO-1:0];
  assign wbits       = bus_gpio_din[NB_GPIO-1:0] & wmask;
  assign wr_en       = (state_q == S_IDLE) && bus_gpio_en && (bus_gpio_bytesel != 4'b0000);
  assign rd_cap      = (state_q == S_IDLE) && bus_gpio_en && (bus_gpio_bytesel == 4'b0000);
  assign unused_bits = ^{bus_gpio_addr, bus_gpio_din, mask32};

  // Bus FSM state register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Bus FSM next state: a read spends one extra cycle in S_RD_DONE, en is ignored there.
  always_comb begin
    state_d = S_IDLE;
    if (rd_cap) state_d = S_RD_DONE;
  end

  // Bus FSM output: only the capture cycle of a read stalls the bus.
  always_comb begin
    gpio_bus_ready_nxt = 1'b1;
    if (!rst && rd_cap) gpio_bus_ready_nxt = 1'b0;
  end

  // Register next state; an incoming rise overrides a same-cycle w1c of that bit.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_stat_d = irq_stat_q;
    if (wr_en) begin
      case (reg_sel)
        GPIO_DATA_OUT: data_out_d = (data_out_q & ~wmask) | wbits;
        GPIO_DIR:      dir_d      = (dir_q & ~wmask) | wbits;
        GPIO_OUT_SET:  data_out_d = data_out_q | wbits;
        GPIO_OUT_CLR:  data_out_d = data_out_q & ~wbits;
        GPIO_IRQ_EN:   irq_en_d   = (irq_en_q & ~wmask) | wbits;
        GPIO_IRQ_STAT: irq_stat_d = irq_stat_q & ~wbits;
        default:       ;
      endcase
    end
    irq_stat_d = irq_stat_d | in_rise;
  end

  // Read mux sees pre-write state; the captured value is held until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_cap) begin
      rdata_d = '0;
      case (reg_sel)
        GPIO_DATA_OUT: rdata_d[NB_GPIO-1:0] = data_out_q;
        GPIO_DATA_IN:  rdata_d[NB_GPIO-1:0] = in_sync;
        GPIO_DIR:      rdata_d[NB_GPIO-1:0] = dir_q;
        GPIO_IRQ_EN:   rdata_d[NB_GPIO-1:0] = irq_en_q;
        GPIO_IRQ_STAT: rdata_d[NB_GPIO-1:0] = irq_stat_q;
        default:       rdata_d = '0;
      endcase
    end
  end

  // Interrupt level tracks pending-and-enabled status one cycle late.
  assign irq_d = |(irq_stat_q & irq_en_q);

  // Register file, read-data and interrupt flops.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_bus_dout = rdata_q;
  assign gpio_out      = data_out_q;
  assign gpio_oe       = dir_q;
  assign gpio_irq      = irq_q;

endmodule

// File: tb/tb_nanorv32_gpio.sv
// tb/tb_nanorv32_gpio.sv - scoreboard bench for nanorv32_gpio
module tb_nanorv32_gpio;
  import nanorv32_gpio_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] bus_gpio_addr;
  logic [3:0]  bus_gpio_bytesel;
  logic [31:0] bus_gpio_din;
  logic        bus_gpio_en;
  logic [31:0] gpio_bus_dout;
  logic        gpio_bus_ready_nxt;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        gpio_irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  nanorv32_gpio #(.NB_GPIO(32), .ADDR_W(32)) dut (
    .clk_in            (clk_in),
    .rst               (rst),
    .bus_gpio_addr     (bus_gpio_addr),
    .bus_gpio_bytesel  (bus_gpio_bytesel),
    .bus_gpio_din      (bus_gpio_din),
    .bus_gpio_en       (bus_gpio_en),
    .gpio_bus_dout     (gpio_bus_dout),
    .gpio_bus_ready_nxt(gpio_bus_ready_nxt),
    .gpio_in           (gpio_in),
    .gpio_out          (gpio_out),
    .gpio_oe           (gpio_oe),
    .gpio_irq          (gpio_irq)
  );

  task automatic set_addr(input logic [2:0] a);
    logic [31:0] av;
    av = $urandom();
    av[4:2] = a;
    bus_gpio_addr = av;
  endtask

  // Drive one write transfer starting just after a rising edge; returns ready seen mid-cycle.
  task automatic drive_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] bs,
                             output logic rdy);
    set_addr(a);
    bus_gpio_bytesel = bs;
    bus_gpio_din     = d;
    bus_gpio_en      = 1'b1;
    @(negedge clk_in);
    rdy = gpio_bus_ready_nxt;
    @(posedge clk_in);
    #1;
  endtask

  // Drive one read transfer (two cycles); returns both ready samples and the completed data.
  task automatic drive_read(input logic [2:0] a, output logic rdy0, output logic rdy1,
                            output logic [31:0] d);
    set_addr(a);
    bus_gpio_bytesel = 4'b0000;
    bus_gpio_din     = $urandom();
    bus_gpio_en      = 1'b1;
    @(negedge clk_in);
    rdy0 = gpio_bus_ready_nxt;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    rdy1 = gpio_bus_ready_nxt;
    d    = gpio_bus_dout;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    bus_gpio_en = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset();
    logic r0, r1, w;
    logic [31:0] d, e;
    logic [2:0]  ra[3];
    logic [31:0] re[3];
    total++;
    if ({gpio_bus_dout, gpio_bus_ready_nxt, gpio_out, gpio_oe, gpio_irq} !== {32'h0, 1'b1, 64'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_held got dout=%h rdy=%b out=%h oe=%h irq=%b", gpio_bus_dout,
               gpio_bus_ready_nxt, gpio_out, gpio_oe, gpio_irq);
    end
    @(negedge clk_in);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      total++;
      if ({gpio_bus_dout, gpio_bus_ready_nxt, gpio_out, gpio_oe, gpio_irq} !== {32'h0, 1'b1, 64'h0, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got dout=%h rdy=%b out=%h oe=%h irq=%b", c, gpio_bus_dout,
                 gpio_bus_ready_nxt, gpio_out, gpio_oe, gpio_irq);
      end
    end
    @(posedge clk_in);
    #1;
    // pin 0 was high through reset: its rise is latched in STAT but not enabled
    ra[0] = GPIO_IRQ_STAT; re[0] = 32'h1;
    ra[1] = GPIO_DATA_IN;  re[1] = 32'h1;
    ra[2] = GPIO_IRQ_EN;   re[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(re[i]);
      drive_read(ra[i], r0, r1, d);
      e = exp_q.pop_front();
      total++;
      if ({r0, r1} !== 2'b01 || d !== e) begin
        bad++;
        $display("FAIL reset_read%0d got rdy=%b%b data=%h want rdy=01 data=%h", i, r0, r1, d, e);
      end
    end
    drive_write(GPIO_IRQ_STAT, 32'h1, 4'b0001, w);
    exp_q.push_back(32'h0);
    drive_read(GPIO_IRQ_STAT, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if (w !== 1'b1 || d !== e) begin
      bad++;
      $display("FAIL reset_w1c got wrdy=%b stat=%h want wrdy=1 stat=%h", w, d, e);
    end
    idle(1);
  endtask

  task automatic test_dir_bytesel();
    logic r0, r1, w;
    logic [31:0] d, e;
    drive_write(GPIO_DIR, 32'hFFFF_1234, 4'b1100, w);
    total++;
    if (w !== 1'b1) begin
      bad++;
      $display("FAIL dir_write_ready got %b want 1", w);
    end
    exp_q.push_back(32'hFFFF_0000);
    drive_read(GPIO_DIR, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if ({r0, r1} !== 2'b01) begin
      bad++;
      $display("FAIL dir_read_ready got %b%b want 01", r0, r1);
    end
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL dir_read_data got %h want %h", d, e);
    end
    total++;
    if (gpio_oe !== 32'hFFFF_0000) begin
      bad++;
      $display("FAIL dir_oe got %h want ffff0000", gpio_oe);
    end
    idle(1);
  endtask

  task automatic test_set_clr();
    logic r0, r1, w;
    logic [31:0] d, e;
    logic [2:0]  ra[5];
    logic [31:0] re[5];
    drive_write(GPIO_DATA_OUT, 32'h0000_00F0, 4'b1111, w);
    drive_write(GPIO_OUT_SET,  32'h0000_0003, 4'b1111, w);
    drive_write(GPIO_OUT_CLR,  32'h0000_0030, 4'b1111, w);
    total++;
    if (gpio_out !== 32'h0000_00C3) begin
      bad++;
      $display("FAIL setclr_out got %h want 000000c3", gpio_out);
    end
    ra[0] = GPIO_DATA_OUT; re[0] = 32'h0000_00C3;
    ra[1] = GPIO_OUT_SET;  re[1] = 32'h0;
    ra[2] = GPIO_OUT_CLR;  re[2] = 32'h0;
    ra[3] = GPIO_RSVD;     re[3] = 32'h0;
    ra[4] = GPIO_DATA_IN;  re[4] = 32'h1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(re[i]);
      drive_read(ra[i], r0, r1, d);
      e = exp_q.pop_front();
      total++;
      if ({r0, r1} !== 2'b01 || d !== e) begin
        bad++;
        $display("FAIL setclr_read%0d got rdy=%b%b data=%h want rdy=01 data=%h", i, r0, r1, d, e);
      end
    end
    // ignored writes, then lane-masked set/clear
    drive_write(GPIO_DATA_IN, 32'hFFFF_FFFF, 4'b1111, w);
    drive_write(GPIO_RSVD,    32'hFFFF_FFFF, 4'b1111, w);
    drive_write(GPIO_OUT_SET, 32'h0101_0100, 4'b0010, w);
    drive_write(GPIO_OUT_CLR, 32'h0000_01FF, 4'b0001, w);
    total++;
    if (gpio_out !== 32'h0000_0100) begin
      bad++;
      $display("FAIL setclr_lanes_out got %h want 00000100", gpio_out);
    end
    ra[0] = GPIO_DATA_OUT; re[0] = 32'h0000_0100;
    ra[1] = GPIO_DATA_IN;  re[1] = 32'h1;
    ra[2] = GPIO_DIR;      re[2] = 32'hFFFF_0000;
    ra[3] = GPIO_IRQ_EN;   re[3] = 32'h0;
    ra[4] = GPIO_IRQ_STAT; re[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(re[i]);
      drive_read(ra[i], r0, r1, d);
      e = exp_q.pop_front();
      total++;
      if ({r0, r1} !== 2'b01 || d !== e) begin
        bad++;
        $display("FAIL setclr_after%0d got rdy=%b%b data=%h want rdy=01 data=%h", i, r0, r1, d, e);
      end
    end
    idle(1);
  endtask

  task automatic test_irq();
    logic r0, r1, w;
    logic [31:0] d, e;
    drive_write(GPIO_IRQ_EN, 32'h0000_0020, 4'b1111, w);
    idle(1);
    gpio_in = 32'h21;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_in);
      #1;
      total++;
      if (gpio_irq !== (k == 4)) begin
        bad++;
        $display("FAIL irq_latency edge=%0d got %b want %b", k, gpio_irq, (k == 4));
      end
    end
    exp_q.push_back(32'h20);
    drive_read(GPIO_IRQ_STAT, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL irq_stat got %h want %h", d, e);
    end
    exp_q.push_back(32'h21);
    drive_read(GPIO_DATA_IN, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL irq_datain got %h want %h", d, e);
    end
    // w1c on unselected lanes must not clear
    drive_write(GPIO_IRQ_STAT, 32'h0000_0020, 4'b1110, w);
    idle(1);
    total++;
    if (gpio_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_w1c_lane got %b want 1", gpio_irq);
    end
    drive_write(GPIO_IRQ_STAT, 32'h0000_0020, 4'b0001, w);
    total++;
    if (gpio_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_w1c_lag got %b want 1", gpio_irq);
    end
    idle(1);
    total++;
    if (gpio_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_w1c_clear got %b want 0", gpio_irq);
    end
    // new rise lands on the same edge as a w1c: set wins
    gpio_in = 32'h1;
    idle(4);
    gpio_in = 32'h21;
    repeat (2) begin
      @(posedge clk_in);
      #1;
    end
    drive_write(GPIO_IRQ_STAT, 32'h0000_0020, 4'b1111, w);
    idle(1);
    total++;
    if (gpio_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins got irq=%b want 1", gpio_irq);
    end
    exp_q.push_back(32'h20);
    drive_read(GPIO_IRQ_STAT, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL irq_set_wins_stat got %h want %h", d, e);
    end
    drive_write(GPIO_IRQ_EN, 32'h0, 4'b1111, w);
    drive_write(GPIO_IRQ_STAT, 32'hFFFF_FFFF, 4'b1111, w);
    idle(2);
    total++;
    if (gpio_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_cleanup got %b want 0", gpio_irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  pat;
    logic [31:0] d1, d2, e;
    drive_write(GPIO_DATA_OUT, 32'h5A5A_A5A5, 4'b1111, pat[5]);
    exp_q.push_back(32'h5A5A_A5A5);
    drive_read(GPIO_DATA_OUT, pat[4], pat[3], d1);
    exp_q.push_back(32'hFFFF_0000);
    drive_read(GPIO_DIR, pat[2], pat[1], d2);
    drive_write(GPIO_DIR, 32'h0000_00FF, 4'b0001, pat[0]);
    idle(1);
    total++;
    if (pat !== 6'b101011) begin
      bad++;
      $display("FAIL b2b_ready got %b want 101011", pat);
    end
    e = exp_q.pop_front();
    total++;
    if (d1 !== e) begin
      bad++;
      $display("FAIL b2b_read1 got %h want %h", d1, e);
    end
    e = exp_q.pop_front();
    total++;
    if (d2 !== e) begin
      bad++;
      $display("FAIL b2b_read2 got %h want %h", d2, e);
    end
    total++;
    if (gpio_oe !== 32'hFFFF_00FF || gpio_out !== 32'h5A5A_A5A5) begin
      bad++;
      $display("FAIL b2b_pads got oe=%h out=%h want oe=ffff00ff out=5a5aa5a5", gpio_oe, gpio_out);
    end
  endtask

  task automatic test_reset_mid_read();
    logic r0, r1, w;
    logic [31:0] d, e;
    set_addr(GPIO_DIR);
    bus_gpio_bytesel = 4'b0000;
    bus_gpio_en      = 1'b1;
    @(posedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (gpio_bus_dout !== 32'h0 || gpio_bus_ready_nxt !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_read got dout=%h rdy=%b want dout=0 rdy=1", gpio_bus_dout, gpio_bus_ready_nxt);
    end
    @(negedge clk_in);
    rst         = 1'b0;
    bus_gpio_en = 1'b0;
    @(posedge clk_in);
    #1;
    total++;
    if (gpio_out !== 32'h0 || gpio_oe !== 32'h0 || gpio_bus_ready_nxt !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_regs got out=%h oe=%h rdy=%b want 0 0 1", gpio_out, gpio_oe, gpio_bus_ready_nxt);
    end
    drive_write(GPIO_DIR, 32'h0000_1234, 4'b1111, w);
    exp_q.push_back(32'h0000_1234);
    drive_read(GPIO_DIR, r0, r1, d);
    e = exp_q.pop_front();
    total++;
    if (w !== 1'b1 || {r0, r1} !== 2'b01 || d !== e) begin
      bad++;
      $display("FAIL rst_mid_after got wrdy=%b rdy=%b%b data=%h want 1 01 %h", w, r0, r1, d, e);
    end
    idle(1);
  endtask

  initial begin
    rst              = 1'b1;
    bus_gpio_addr    = 32'h0;
    bus_gpio_bytesel = 4'b0000;
    bus_gpio_din     = 32'h0;
    bus_gpio_en      = 1'b0;
    gpio_in          = 32'h1;
    repeat (3) @(posedge clk_in);
    #1;
    test_reset();
    test_dir_bytesel();
    test_set_clr();
    test_irq();
    test_back_to_back();
    test_reset_mid_read();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_gpio.md
Name: nanorv32_gpio

Overview:
- Downstream consumer of the AHB-to-peripheral bridge's simple bus (bus_gpio_* / gpio_bus_*).
- Register-mapped general-purpose I/O block: output data, direction, synchronised input sampling, rising-edge interrupt capture.
- Writes complete with zero wait states; reads insert exactly one wait state through gpio_bus_ready_nxt, which drives hreadyout directly.

Parameters:
- NB_GPIO, 32, number of GPIO pins (1..32); register bits above NB_GPIO-1 read 0 and ignore writes.
- ADDR_W, 32, width of bus_gpio_addr (NANORV32_PERIPH_ADDR_MSB+1).

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- bus_gpio_addr  input  ADDR_W  byte address; only [4:2] decoded, upper bits alias
- bus_gpio_bytesel  input  4  byte lanes; nonzero = write, 4'b0000 = read
- bus_gpio_din  input  32  write data, valid while bus_gpio_en=1
- bus_gpio_en  input  1  transfer active (data phase)
- gpio_bus_dout  output  32  read data, valid when gpio_bus_ready_nxt=1 completes a read
- gpio_bus_ready_nxt  output  1  transfer completion / hreadyout
- gpio_in  input  NB_GPIO  asynchronous pad inputs
- gpio_out  output  NB_GPIO  pad output values (= DATA_OUT)
- gpio_oe  output  NB_GPIO  pad output enables (= DIR, 1 = output)
- gpio_irq  output  1  level interrupt, registered

Behaviour:
- Reset (async, rst=1): all registers 0; gpio_bus_dout=0, gpio_bus_ready_nxt=1, gpio_out=0, gpio_oe=0, gpio_irq=0, FSM=S_IDLE, sync/edge flops 0.
- Register map (addr[4:2]):
  - 0 DATA_OUT rw
  - 1 DATA_IN ro (synced input); writes ignored
  - 2 DIR rw
  - 3 OUT_SET wo: DATA_OUT |= wdata; reads 0
  - 4 OUT_CLR wo: DATA_OUT &= ~wdata; reads 0
  - 5 IRQ_EN rw
  - 6 IRQ_STAT r/w1c
  - 7 reserved: reads 0, writes ignored
- Byte lanes: a write affects only bytes with bytesel[i]=1, including the SET/CLR/w1c masks.
- Input path: 2-flop synchroniser per pin, then a prev flop. A rise is sync=1 & prev=0. DATA_IN = sync value. Latency from pad to DATA_IN is 2 cycles.
  - Pin high at reset release yields a rise 2 cycles later and sets STAT. IRQ_EN=0 at reset, so no interrupt results.
- IRQ_STAT[i] sets on rise[i] regardless of IRQ_EN. If a rise and a w1c for the same bit occur in the same cycle, the set wins.
- gpio_irq is a flop of |(IRQ_STAT & IRQ_EN), so it follows the state with 1 cycle of latency.
- FSM (2 states):
  - S_IDLE, en=0: ready_nxt=1, nothing happens.
  - S_IDLE, en=1, bytesel!=0: write commits at this edge; ready_nxt=1 combinationally; stay S_IDLE. Back-to-back writes run at 1 per cycle.
  - S_IDLE, en=1, bytesel=0: ready_nxt=0; selected read value is captured into the rdata flop; go to S_RD_DONE.
  - S_RD_DONE: ready_nxt=1; gpio_bus_dout=captured value; en is ignored this cycle (same transfer); go to S_IDLE.
  - en=1 in the following S_IDLE cycle is a new transfer, so back-to-back reads run at 1 per 2 cycles.
- gpio_bus_dout holds its last captured value outside read completion. It returns to 0 only on reset.
- Reads reflect register state before any write committing at the same edge; no write can coincide with the capture edge.
- Reset mid-read (S_RD_DONE or capture cycle): FSM returns to S_IDLE, ready_nxt=1, dout=0; the pending read is dropped.

Decomposition:
- Shared package/include (nanorv32_parameters.v): register offset constants GPIO_DATA_OUT..GPIO_IRQ_STAT (3'd0..3'd6), FSM state encodings.
- One sub-module, nanorv32_gpio_sync: parameterised NB_GPIO-wide 2-flop synchroniser plus prev flop, outputs sync and rise vectors.
- Bus FSM and register file stay in the top module.

Test Plan:
- Reset then idle: dout=0, ready_nxt=1, gpio_out=0, gpio_oe=0, gpio_irq=0 throughout.
- Write DIR=0xFFFF_0000 with bytesel=4'b1100, then read DIR: ready_nxt=0 for 1 cycle, then dout=0xFFFF_0000 with ready_nxt=1.
- DATA_OUT=0x0000_00F0; OUT_SET 0x0000_0003; OUT_CLR 0x0000_0030: gpio_out=0x0000_00C3 one cycle after the last write; DATA_OUT read returns 0x0000_00C3; OUT_SET read returns 0.
- Raise gpio_in[5] with IRQ_EN=0x20: IRQ_STAT[5]=1 3 cycles after the rise, gpio_irq=1 one cycle after that. Write IRQ_STAT=0x20 → gpio_irq=0 two cycles later. Repeat with the w1c on the same edge as a new rise: bit stays 1.
- Back-to-back write, read, read, write with en held high: ready_nxt pattern 1,0,1,0,1,1; both reads return correct values.
- Assert rst during S_RD_DONE: dout=0 and ready_nxt=1 immediately (async); next transfer after release completes normally.
